// File: rtl/sweep_pkg.sv
// Shared types, constants and the MISR update function for the sweep blocks.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned MISR_W       = 16;
  localparam logic [15:0] DEFAULT_POLY = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

  // One MISR shift: shift left, fold in poly on carry-out, xor the new data.
  function automatic logic [MISR_W-1:0] misr_step(
    input logic [MISR_W-1:0] sig,
    input logic [MISR_W-1:0] data,
    input logic [MISR_W-1:0] poly
  );
    logic [MISR_W-1:0] nxt;
    nxt = {sig[MISR_W-2:0], 1'b0};
    if (sig[MISR_W-1]) begin
      nxt = nxt ^ poly;
    end
    return nxt ^ data;
  endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit signature register: reset/load to SEED, step folds in one data word.
module misr16
  import sweep_pkg::*;
#(
  parameter logic [MISR_W-1:0] SEED = DEFAULT_SEED,
  parameter logic [MISR_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [MISR_W-1:0] data,
  output logic [MISR_W-1:0] sig
);

  // Signature register; load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= misr_step(sig, data, POLY);
    end
  end

endmodule

// File: rtl/circuit_sweep.sv
// Exhaustive input sweep of a combinational block with MISR response compaction.
// Every vector is held SETTLE cycles, then sampled for one cycle; results are
// held behind a valid/ready handshake until the next accepted start.
module circuit_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned       N_IN   = 5,
  parameter int unsigned       N_OUT  = 5,
  parameter int unsigned       SETTLE = 1,
  parameter logic [MISR_W-1:0] SEED   = DEFAULT_SEED,
  parameter logic [MISR_W-1:0] POLY   = DEFAULT_POLY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MISR_W-1:0] signature,
  output logic [N_IN:0]     hit_count
);

  localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = '1;

  state_t            state;
  state_t            next_state;
  logic [N_IN-1:0]   idx;
  logic [N_IN-1:0]   idx_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [N_IN-1:0]   dut_in_d;
  logic              busy_d;
  logic              res_valid_d;
  logic [N_IN:0]     hit_count_d;
  logic              sig_load;
  logic              sig_step;
  logic [MISR_W-1:0] sig_data;

  assign sig_data = MISR_W'(dut_out);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dut_in    <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      hit_count <= '0;
    end else begin
      state     <= next_state;
      idx       <= idx_d;
      cnt       <= cnt_d;
      dut_in    <= dut_in_d;
      busy      <= busy_d;
      res_valid <= res_valid_d;
      hit_count <= hit_count_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    next_state  = state;
    idx_d       = idx;
    cnt_d       = cnt;
    dut_in_d    = dut_in;
    busy_d      = 1'b0;
    res_valid_d = 1'b0;
    hit_count_d = hit_count;
    sig_load    = 1'b0;
    sig_step    = 1'b0;

    case (state)
      IDLE: begin
        dut_in_d = '0;
        if (start) begin
          next_state  = DRIVE;
          idx_d       = '0;
          cnt_d       = '0;
          hit_count_d = '0;
          sig_load    = 1'b1;
        end
      end

      DRIVE: begin
        dut_in_d = idx;
        busy_d   = 1'b1;
        if (cnt == CNT_LAST) begin
          next_state = SAMPLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      SAMPLE: begin
        dut_in_d = idx;
        busy_d   = 1'b1;
        sig_step = 1'b1;
        if (dut_out != '0) begin
          hit_count_d = hit_count + 1'b1;
        end
        // Last-vector compare ends the sweep so idx never wraps.
        if (idx == IDX_LAST) begin
          next_state = DONE;
        end else begin
          idx_d      = idx + 1'b1;
          cnt_d      = '0;
          next_state = DRIVE;
        end
      end

      DONE: begin
        res_valid_d = 1'b1;
        if (res_valid && res_ready) begin
          next_state  = IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  misr16 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (sig_load),
    .step (sig_step),
    .data (sig_data),
    .sig  (signature)
  );

endmodule

// File: tb/tb_circuit_sweep.sv
// Scoreboard bench for circuit_sweep: SETTLE=1 and SETTLE=3 instances, several
// circuit stand-ins, start/ready protocol corners and mid-sweep reset.
module tb_circuit_sweep;

  logic        clk;
  logic        rst;
  logic        start1, start3;
  logic        rdy1, rdy3;
  logic [4:0]  din1, din3;
  logic [4:0]  dout1, dout3;
  logic        busy1, busy3;
  logic        rv1, rv3;
  logic [15:0] sig1, sig3;
  logic [5:0]  hit1, hit3;
  int          mode1, mode3;

  int n_checks;
  int n_err;

  logic [21:0] exp_q[$];

  circuit_sweep #(.N_IN(5), .N_OUT(5), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .dut_in(din1),
    .dut_out(dout1), .res_valid(rv1), .res_ready(rdy1), .signature(sig1),
    .hit_count(hit1)
  );

  circuit_sweep #(.N_IN(5), .N_OUT(5), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .dut_in(din3),
    .dut_out(dout3), .res_valid(rv3), .res_ready(rdy3), .signature(sig3),
    .hit_count(hit3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-ins for the generated combinational circuit.
  function automatic logic [4:0] resp(input int m, input logic [4:0] v);
    case (m)
      0:       return 5'd0;
      1:       return v;
      2:       return {3'b000, v[1], v[2]};
      default: return 5'(v * 5'd3) ^ 5'h09;
    endcase
  endfunction

  always_comb dout1 = resp(mode1, din1);
  always_comb dout3 = resp(mode3, din3);

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [4:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h002D;
    return n ^ {11'd0, d};
  endfunction

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start3 = v; else start1 = v;
  endtask

  // Push the model result, run one sweep, pop and compare at res_valid.
  task automatic run_sweep(input bit sel, input int m, input bit poke);
    int          cyc, busy_n, seq_bad, stab_bad, settle, span;
    logic [15:0] esig, held;
    logic [5:0]  ehit;
    logic [4:0]  d;
    logic [21:0] e;

    settle = sel ? 3 : 1;
    span   = 32 * (settle + 1);
    esig   = 16'hFFFF;
    ehit   = 6'd0;
    for (int v = 0; v < 32; v++) begin
      d    = resp(m, 5'(v));
      esig = mstep(esig, d);
      if (d != 5'd0) ehit = ehit + 6'd1;
    end
    exp_q.push_back({esig, ehit});

    if (sel) mode3 = m; else mode1 = m;
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);

    cyc = 0; busy_n = 0; seq_bad = 0;
    while (!(sel ? rv3 : rv1) && cyc < 400) begin
      tick();
      cyc++;
      if (sel ? busy3 : busy1) busy_n++;
      if (cyc <= span && (sel ? din3 : din1) != 5'((cyc - 1) / (settle + 1))) seq_bad++;
      if (poke && cyc == 5) set_start(sel, 1'b1);
      if (poke && cyc == 6) set_start(sel, 1'b0);
    end
    check("latency", cyc, span + 1);
    check("busy_cycles", busy_n, span);
    check("drive_seq", seq_bad, 0);

    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("signature", int'(sel ? sig3 : sig1), int'(e[21:6]));
      check("hit_count", int'(sel ? hit3 : hit1), int'(e[5:0]));
    end

    if (poke) begin
      held = sel ? sig3 : sig1;
      stab_bad = 0;
      for (int i = 0; i < 10; i++) begin
        set_start(sel, (i == 2) ? 1'b1 : 1'b0);
        tick();
        if (!(sel ? rv3 : rv1) || (sel ? sig3 : sig1) != held || (sel ? busy3 : busy1)) stab_bad++;
      end
      set_start(sel, 1'b0);
      check("done_stable", stab_bad, 0);
    end

    if (sel) rdy3 = 1'b1; else rdy1 = 1'b1;
    tick();
    if (sel) rdy3 = 1'b0; else rdy1 = 1'b0;
    check("rv_drop", int'(sel ? rv3 : rv1), 0);
    tick();
    check("idle_dut_in", int'(sel ? din3 : din1), 0);
    check("idle_busy", int'(sel ? busy3 : busy1), 0);
  endtask

  initial begin
    int seen_rv, found, guard;
    n_checks = 0; n_err = 0;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; rdy1 = 1'b0; rdy3 = 1'b0;
    mode1 = 0; mode3 = 0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_busy", int'(busy1), 0);
    check("rst_rv", int'(rv1), 0);
    check("rst_dut_in", int'(din1), 0);
    check("rst_sig", int'(sig1), 16'hFFFF);
    check("rst_hit", int'(hit1), 0);

    run_sweep(1'b0, 0, 1'b0);
    check("zero_hits", int'(hit1), 0);
    run_sweep(1'b0, 1, 1'b0);
    check("loop_hits", int'(hit1), 31);
    run_sweep(1'b0, 2, 1'b0);
    check("x1x2_hits", int'(hit1), 24);
    run_sweep(1'b0, 3, 1'b1);

    // Reset at vector 17 abandons the sweep without a result.
    mode1 = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    seen_rv = 0; found = 0; guard = 0;
    while (!found && guard < 200) begin
      tick();
      guard++;
      if (rv1) seen_rv++;
      if (din1 == 5'd17) found = 1;
    end
    check("abort_reach17", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rv1) seen_rv++;
    end
    check("abort_no_rv", seen_rv, 0);
    check("abort_busy", int'(busy1), 0);
    check("abort_sig", int'(sig1), 16'hFFFF);
    check("abort_hit", int'(hit1), 0);
    run_sweep(1'b0, 1, 1'b0);

    // Reset wins over a simultaneous start.
    rst = 1'b1; start1 = 1'b1;
    tick();
    rst = 1'b0; start1 = 1'b0;
    tick();
    check("rst_start_busy", int'(busy1), 0);
    tick();
    check("rst_start_busy2", int'(busy1), 0);

    run_sweep(1'b1, 1, 1'b0);
    run_sweep(1'b1, 2, 1'b0);
    check("settle3_x1x2_hits", int'(hit3), 24);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
